// File: rtl/axis_dma_pkg.sv
// Shared types and AXI attribute constants for the stream-to-memory DMA writer.
// Also holds the legality check for the burst length parameter.
package axis_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP
   } dma_state_e;

   localparam logic [2:0] AXI_SIZE_4B          = 3'b010;
   localparam logic [3:0] AXI_CACHE_BUFFERABLE = 4'b0011;
   localparam logic [2:0] AXI_PROT_DEFAULT     = 3'b000;

   // Bursts must be a power of two so aligned bases never straddle a 4 KB page.
   function automatic bit burst_len_legal(input int unsigned len);
      return (len >= 1) && (len <= 256) && ((len & (len - 1)) == 0);
   endfunction

endpackage

// File: rtl/axis_dma_writer.sv
// AXI-Stream to AXI4 write DMA: splits a word count into INCR bursts of up to
// BURST_LEN beats, one burst outstanding, W data passed straight from the stream.
module axis_dma_writer
   import axis_dma_pkg::*;
#(
   parameter int BURST_LEN = 16,
   parameter int LEN_WIDTH = 24
) (
   input  logic                 aclk,
   input  logic                 arst,
   input  logic                 start,
   input  logic [31:0]          base_addr,
   input  logic [LEN_WIDTH-1:0] length,
   output logic                 busy,
   output logic                 done,
   input  logic [31:0]          s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [31:0]          m_axi_awaddr,
   output logic [7:0]           m_axi_awlen,
   output logic [2:0]           m_axi_awsize,
   output logic [3:0]           m_axi_awcache,
   output logic [2:0]           m_axi_awprot,
   output logic                 m_axi_awvalid,
   input  logic                 m_axi_awready,
   output logic [31:0]          m_axi_wdata,
   output logic [3:0]           m_axi_wstrb,
   output logic                 m_axi_wlast,
   output logic                 m_axi_wvalid,
   input  logic                 m_axi_wready,
   input  logic                 m_axi_bvalid,
   output logic                 m_axi_bready
);

   if (!burst_len_legal(BURST_LEN)) begin : g_bad_burst_len
      $error("BURST_LEN must be a power of two in 1..256");
   end

   dma_state_e           state_q, state_d;
   logic [31:0]          addr_q;
   logic [LEN_WIDTH-1:0] rem_q;
   logic [7:0]           awlen_q;
   logic [7:0]           beat_q;
   logic                 done_q;
   logic                 zero_job_q;
   logic [LEN_WIDTH-1:0] rem_after;
   logic [31:0]          addr_after;

   function automatic logic [7:0] burst_awlen(input logic [LEN_WIDTH-1:0] words);
      if (words >= LEN_WIDTH'(BURST_LEN)) return 8'(BURST_LEN - 1);
      return 8'(words - LEN_WIDTH'(1));
   endfunction

   assign rem_after  = rem_q - (LEN_WIDTH'(awlen_q) + LEN_WIDTH'(1));
   assign addr_after = addr_q + 32'({awlen_q, 2'b00}) + 32'd4;

   always_ff @(posedge aclk) begin
      if (arst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      s_axis_tready = 1'b0;
      m_axi_bready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && (length != '0)) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_d = ST_DATA;
         end
         ST_DATA: begin
            m_axi_wvalid  = s_axis_tvalid;
            s_axis_tready = m_axi_wready;
            m_axi_wlast   = (beat_q == 8'd0);
            if (s_axis_tvalid && m_axi_wready && (beat_q == 8'd0)) state_d = ST_RESP;
         end
         ST_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_d = (rem_after == '0) ? ST_IDLE : ST_ADDR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // awlen for the next burst is computed as soon as the remaining count is known,
   // so the AW channel presents registered values the whole time it waits.
   always_ff @(posedge aclk) begin
      if (arst) begin
         addr_q     <= '0;
         rem_q      <= '0;
         awlen_q    <= '0;
         beat_q     <= '0;
         done_q     <= 1'b0;
         zero_job_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         zero_job_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q <= base_addr;
                  rem_q  <= length;
                  if (length == '0) begin
                     done_q     <= 1'b1;
                     zero_job_q <= 1'b1;
                  end else begin
                     awlen_q <= burst_awlen(length);
                  end
               end
            end
            ST_ADDR: begin
               if (m_axi_awready) beat_q <= awlen_q;
            end
            ST_DATA: begin
               if (s_axis_tvalid && m_axi_wready) beat_q <= beat_q - 8'd1;
            end
            ST_RESP: begin
               if (m_axi_bvalid) begin
                  rem_q  <= rem_after;
                  addr_q <= addr_after;
                  if (rem_after == '0) done_q <= 1'b1;
                  else                 awlen_q <= burst_awlen(rem_after);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy          = (state_q != ST_IDLE) || zero_job_q;
   assign done          = done_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = awlen_q;
   assign m_axi_awsize  = AXI_SIZE_4B;
   assign m_axi_awcache = AXI_CACHE_BUFFERABLE;
   assign m_axi_awprot  = AXI_PROT_DEFAULT;
   assign m_axi_wdata   = s_axis_tdata;
   assign m_axi_wstrb   = 4'hF;

endmodule
